// File: rtl/tpu_pkg.sv
// Shared TinyTPU constants and the result collector output FSM encoding.
package tpu_pkg;

  localparam int unsigned D_W             = 8;
  localparam int unsigned N               = 2;
  localparam int unsigned OUT_W           = 8;
  localparam int unsigned FIFO_DEPTH      = 4;
  localparam int unsigned Z_W             = 2 * D_W;
  localparam int unsigned WORDS_PER_FRAME = N * N;
  localparam int unsigned SLICES_PER_WORD = Z_W / OUT_W;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } out_state_e;

endpackage

// File: rtl/tpu_result_collector_if.sv
// Serial result input and byte valid/ready output of the result collector.
// byte_last exists only when RESULT_COLLECTOR_LAST_EN is defined.
interface tpu_result_collector_if #(
    parameter int unsigned OUT_W = 8
);

    logic             serial_z;
    logic             serial_valid;
    logic [OUT_W-1:0] byte_out;
    logic             byte_valid;
    logic             byte_ready;
`ifdef RESULT_COLLECTOR_LAST_EN
    logic             byte_last;
`endif

    modport master (
        output serial_z, serial_valid, byte_ready,
`ifdef RESULT_COLLECTOR_LAST_EN
        input  byte_last,
`endif
        input  byte_out, byte_valid
    );

    modport slave (
        input  serial_z, serial_valid, byte_ready,
`ifdef RESULT_COLLECTOR_LAST_EN
        output byte_last,
`endif
        output byte_out, byte_valid
    );

endinterface

// File: rtl/tpu_word_fifo.sv
// Synchronous word FIFO; exposes the head entry and the one behind it so the
// reader can switch words without a bubble.
module tpu_word_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic [Width-1:0]         second_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o   = (count_q == LvlW'(Depth));
    assign empty_o  = (count_q == '0);
    assign level_o  = count_q;
    assign head_o   = mem_q[rd_ptr_q];
    assign second_o = mem_q[rd_ptr_q + PtrW'(1)];

    // A pop frees the slot, so a push into a full FIFO is allowed alongside it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + LvlW'(1);
            else if (do_pop && !do_push) count_q <= count_q - LvlW'(1);
        end
    end

endmodule

// File: rtl/tpu_result_collector.sv
// Rebuilds serial TinyTPU results into words, buffers them and emits byte slices.
// Define RESULT_COLLECTOR_LAST_EN to add byte_last marking the frame's final slice.
module tpu_result_collector #(
    parameter int unsigned D_W        = tpu_pkg::D_W,
    parameter int unsigned N          = tpu_pkg::N,
    parameter int unsigned OUT_W      = tpu_pkg::OUT_W,
    parameter int unsigned FIFO_DEPTH = tpu_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    tpu_result_collector_if.slave         bus,
    input  logic                          frame_sync_i,
    input  logic                          ovf_clr_i,
    output logic                          frame_done_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    import tpu_pkg::*;

    localparam int unsigned ZW       = 2 * D_W;
    localparam int unsigned Wpf      = N * N;
    localparam int unsigned Spw      = ZW / OUT_W;
    localparam int unsigned BitCntW  = $clog2(ZW);
    localparam int unsigned WordCntW = (Wpf > 1) ? $clog2(Wpf) : 1;
    localparam int unsigned SliceW   = (Spw > 1) ? $clog2(Spw) : 1;
    localparam int unsigned LvlW     = $clog2(FIFO_DEPTH) + 1;
`ifdef RESULT_COLLECTOR_LAST_EN
    localparam int unsigned EntryW   = ZW + 1;
`else
    localparam int unsigned EntryW   = ZW;
`endif

    logic [ZW-2:0]       partial_q, partial_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
    logic                push_pend_q, push_pend_d;
    logic                push_last_q, push_last_d;
    logic [ZW-1:0]       push_word_q, push_word_d;
    logic                overflow_q, overflow_d;
    out_state_e          state_q, state_d;
    logic [SliceW-1:0]   slice_q, slice_d;
    logic [OUT_W-1:0]    byte_q, byte_d;
    logic                valid_q, valid_d;
`ifdef RESULT_COLLECTOR_LAST_EN
    logic                last_q, last_d;
`endif

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [LvlW-1:0]       fifo_level;
    logic [EntryW-1:0]     fifo_wdata, fifo_head, fifo_second, next_entry;
    logic [Spw-1:0][OUT_W-1:0] head_sl, next_sl;
    logic                  stay_send;

    // Deserialiser: bits arrive LSB first, the final bit completes the word.
    always_comb begin
        partial_d   = partial_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        push_pend_d = 1'b0;
        push_word_d = push_word_q;
        push_last_d = push_last_q;
        if (frame_sync_i) begin
            partial_d  = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (bus.serial_valid) begin
            if (bit_cnt_q == BitCntW'(ZW - 1)) begin
                push_pend_d = 1'b1;
                push_word_d = {bus.serial_z, partial_q};
                push_last_d = (word_cnt_q == WordCntW'(Wpf - 1));
                partial_d   = '0;
                bit_cnt_d   = '0;
                word_cnt_d  = push_last_d ? '0 : word_cnt_q + WordCntW'(1);
            end else begin
                partial_d = {bus.serial_z, partial_q[ZW-2:1]};
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
            end
        end
    end

    assign fifo_pop     = (state_q == StSend) && valid_q && bus.byte_ready &&
                          (slice_q == SliceW'(Spw - 1));
    assign fifo_push    = push_pend_q && (!fifo_full || fifo_pop);
    assign overflow_d   = (push_pend_q && !fifo_push) ? 1'b1 : (ovf_clr_i ? 1'b0 : overflow_q);
    assign frame_done_o = push_pend_q && push_last_q;
`ifdef RESULT_COLLECTOR_LAST_EN
    assign fifo_wdata   = {push_last_q, push_word_q};
`else
    assign fifo_wdata   = push_word_q;
`endif

    tpu_word_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (fifo_push),
        .wdata_i  (fifo_wdata),
        .pop_i    (fifo_pop),
        .head_o   (fifo_head),
        .second_o (fifo_second),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .level_o  (fifo_level)
    );

    // With one entry left, the word replacing the head is the one being pushed now.
    assign next_entry = (fifo_level == LvlW'(1)) ? fifo_wdata : fifo_second;
    assign stay_send  = (fifo_level > LvlW'(1)) || fifo_push;
    assign head_sl    = fifo_head[ZW-1:0];
    assign next_sl    = next_entry[ZW-1:0];

    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        byte_d  = byte_q;
        valid_d = valid_q;
`ifdef RESULT_COLLECTOR_LAST_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StSend;
                    valid_d = 1'b1;
                    slice_d = '0;
                    byte_d  = head_sl[0];
`ifdef RESULT_COLLECTOR_LAST_EN
                    last_d  = fifo_head[ZW] && (Spw == 1);
`endif
                end
            end
            StSend: begin
                if (valid_q && bus.byte_ready) begin
                    if (slice_q == SliceW'(Spw - 1)) begin
                        slice_d = '0;
                        if (stay_send) begin
                            byte_d = next_sl[0];
`ifdef RESULT_COLLECTOR_LAST_EN
                            last_d = next_entry[ZW] && (Spw == 1);
`endif
                        end else begin
                            state_d = StIdle;
                            valid_d = 1'b0;
`ifdef RESULT_COLLECTOR_LAST_EN
                            last_d  = 1'b0;
`endif
                        end
                    end else begin
                        slice_d = slice_q + SliceW'(1);
                        byte_d  = head_sl[slice_d];
`ifdef RESULT_COLLECTOR_LAST_EN
                        last_d  = fifo_head[ZW] && (slice_d == SliceW'(Spw - 1));
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            partial_q   <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            push_pend_q <= 1'b0;
            push_word_q <= '0;
            push_last_q <= 1'b0;
            overflow_q  <= 1'b0;
            state_q     <= StIdle;
            slice_q     <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
`ifdef RESULT_COLLECTOR_LAST_EN
            last_q      <= 1'b0;
`endif
        end else begin
            partial_q   <= partial_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            push_pend_q <= push_pend_d;
            push_word_q <= push_word_d;
            push_last_q <= push_last_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            slice_q     <= slice_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
`ifdef RESULT_COLLECTOR_LAST_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.byte_out    = byte_q;
    assign bus.byte_valid  = valid_q;
`ifdef RESULT_COLLECTOR_LAST_EN
    assign bus.byte_last   = last_q;
`endif
    assign overflow_o      = overflow_q;
    assign fifo_level_o    = fifo_level;

endmodule

// File: tb/tb_tpu_result_collector.sv
// Directed bench for tpu_result_collector (D_W=8, N=2, OUT_W=8, FIFO_DEPTH=4).
module tb_tpu_result_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_sync, ovf_clr, frame_done, overflow;
    logic [2:0] fifo_level;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic       last_q[$];

    tpu_result_collector_if #(.OUT_W(8)) bus_if ();

    tpu_result_collector #(
        .D_W        (8),
        .N          (2),
        .OUT_W      (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if.slave),
        .frame_sync_i (frame_sync),
        .ovf_clr_i    (ovf_clr),
        .frame_done_o (frame_done),
        .overflow_o   (overflow),
        .fifo_level_o (fifo_level)
    );

    always #5 clk = ~clk;

    // Record accepted bytes mid-cycle, ahead of the edge that accepts them.
    always @(negedge clk) begin
        if (bus_if.byte_valid && bus_if.byte_ready) begin
            got_q.push_back(bus_if.byte_out);
`ifdef RESULT_COLLECTOR_LAST_EN
            last_q.push_back(bus_if.byte_last);
`else
            last_q.push_back(1'b0);
`endif
        end
        if (frame_done) fd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.serial_valid = 1'b0;
        bus_if.serial_z = 1'b0;
        frame_sync = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        last_q.delete();
        fd_cnt = 0;
    endtask

    task automatic send_bit(input logic b);
        bus_if.serial_z = b;
        bus_if.serial_valid = 1'b1;
        tick();
        bus_if.serial_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_bit(w[i]);
        end
    endtask

    task automatic expect_word(input logic [15:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
    endtask

    task automatic drain_and_check(input string tag);
        for (int i = 0; i < 80 && got_q.size() < exp_q.size(); i++) tick();
        repeat (4) tick();
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        bus_if.byte_ready = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_byte_out", 32'(bus_if.byte_out), 32'h0);
        check_eq("rst_byte_valid", 32'(bus_if.byte_valid), 32'h0);
        check_eq("rst_frame_done", 32'(frame_done), 32'h0);
        check_eq("rst_overflow", 32'(overflow), 32'h0);
        check_eq("rst_level", 32'(fifo_level), 32'h0);

        // Single word with exact latency
        bus_if.byte_ready = 1'b1;
        send_word(16'h1234, 1'b0);
        check_eq("lat_e0_valid", 32'(bus_if.byte_valid), 32'h0);
        tick();
        check_eq("lat_e1_valid", 32'(bus_if.byte_valid), 32'h0);
        tick();
        check_eq("lat_e2_valid", 32'(bus_if.byte_valid), 32'h1);
        check_eq("lat_e2_byte", 32'(bus_if.byte_out), 32'h34);
        tick();
        check_eq("lat_e3_valid", 32'(bus_if.byte_valid), 32'h1);
        check_eq("lat_e3_byte", 32'(bus_if.byte_out), 32'h12);
        tick();
        check_eq("lat_e4_valid", 32'(bus_if.byte_valid), 32'h0);
        expect_word(16'h1234);
        drain_and_check("single");

        // Full frame with random gaps
        do_reset();
        bus_if.byte_ready = 1'b1;
        send_word(16'h0001, 1'b1);
        send_word(16'h00FF, 1'b1);
        send_word(16'h8000, 1'b1);
        check_eq("frame_fd_w2", 32'(frame_done), 32'h0);
        send_word(16'hFFFF, 1'b1);
        check_eq("frame_fd_w3", 32'(frame_done), 32'h1);
        expect_word(16'h0001);
        expect_word(16'h00FF);
        expect_word(16'h8000);
        expect_word(16'hFFFF);
        drain_and_check("frame");
        check_eq("frame_fd_count", 32'(fd_cnt), 32'd1);
`ifdef RESULT_COLLECTOR_LAST_EN
        for (int i = 0; i < last_q.size(); i++)
            check_eq($sformatf("frame_last%0d", i), 32'(last_q[i]), (i == 7) ? 32'h1 : 32'h0);
`endif

        // Backpressure and overflow
        do_reset();
        bus_if.byte_ready = 1'b0;
        send_word(16'h1111, 1'b0);
        send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0);
        send_word(16'h4444, 1'b0);
        tick();
        check_eq("bp_level4", 32'(fifo_level), 32'd4);
        check_eq("bp_ovf_before", 32'(overflow), 32'h0);
        send_word(16'h5555, 1'b0);
        tick();
        check_eq("bp_level_after5", 32'(fifo_level), 32'd4);
        check_eq("bp_ovf_set", 32'(overflow), 32'h1);
        check_eq("bp_hold_byte", 32'(bus_if.byte_out), 32'h11);
        bus_if.byte_ready = 1'b1;
        expect_word(16'h1111);
        expect_word(16'h2222);
        expect_word(16'h3333);
        expect_word(16'h4444);
        drain_and_check("bp");
        check_eq("bp_ovf_sticky", 32'(overflow), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("bp_ovf_clr", 32'(overflow), 32'h0);

        // Full FIFO with the head's last slice popped as a new word lands
        do_reset();
        bus_if.byte_ready = 1'b0;
        send_word(16'h0102, 1'b0);
        send_word(16'h0304, 1'b0);
        send_word(16'h0506, 1'b0);
        send_word(16'h0708, 1'b0);
        tick();
        check_eq("fp_level_full", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 15; i++) send_bit(((16'h090A >> i) & 16'h1) != 0);
        bus_if.byte_ready = 1'b1;
        send_bit(1'b0);
        tick();
        bus_if.byte_ready = 1'b0;
        check_eq("fp_level", 32'(fifo_level), 32'd4);
        check_eq("fp_ovf", 32'(overflow), 32'h0);
        bus_if.byte_ready = 1'b1;
        expect_word(16'h0102);
        expect_word(16'h0304);
        expect_word(16'h0506);
        expect_word(16'h0708);
        expect_word(16'h090A);
        drain_and_check("fp");

        // frame_sync mid-word keeps buffered data
        do_reset();
        bus_if.byte_ready = 1'b0;
        send_word(16'h7777, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        frame_sync = 1'b1;
        send_bit(1'b1);
        frame_sync = 1'b0;
        send_word(16'hA5C3, 1'b0);
        tick();
        check_eq("fs_level", 32'(fifo_level), 32'd2);
        bus_if.byte_ready = 1'b1;
        expect_word(16'h7777);
        expect_word(16'hA5C3);
        drain_and_check("fs");

        // Reset mid-stream
        bus_if.byte_ready = 1'b0;
        got_q.delete();
        exp_q.delete();
        send_word(16'h1357, 1'b0);
        send_word(16'h2468, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check_eq("mr_level_pre", 32'(fifo_level), 32'd2);
        check_eq("mr_valid_pre", 32'(bus_if.byte_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_byte_out", 32'(bus_if.byte_out), 32'h0);
        check_eq("mr_byte_valid", 32'(bus_if.byte_valid), 32'h0);
        check_eq("mr_frame_done", 32'(frame_done), 32'h0);
        check_eq("mr_overflow", 32'(overflow), 32'h0);
        check_eq("mr_level", 32'(fifo_level), 32'h0);
        got_q.delete();
        bus_if.byte_ready = 1'b1;
        send_word(16'hBEEF, 1'b0);
        expect_word(16'hBEEF);
        drain_and_check("mr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
